// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised integer register file with a per-register busy scoreboard
//   for a pipelined core. Decode/issue reads operands through two
//   combinational read ports and reserves a destination register through the
//   issue port. Writeback stores data and releases the reservation.
//
// Parameters
//   XLEN      data width of each register
//   NREGS     number of architectural registers (power of 2, >= 2)
//   AW        register address width, derived from NREGS (not overridable)
//   ZERO_R0   1: r0 reads 0, ignores writes and is never busy
//   RESET_VAL reset value loaded into every register
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-low reset
//   rs1_addr   in   read port 1 address
//   rs2_addr   in   read port 2 address
//   rs1_data   out  read port 1 data (combinational)
//   rs2_data   out  read port 2 data (combinational)
//   rs1_busy   out  busy bit of rs1_addr (combinational)
//   rs2_busy   out  busy bit of rs2_addr (combinational)
//   iss_valid  in   issue request reserving iss_rd
//   iss_rd     in   destination register to reserve
//   iss_ready  out  issue may be accepted this cycle
//   wb_valid   in   writeback strobe
//   wb_rd      in   writeback register
//   wb_data    in   writeback data
//   flush      in   clear all busy bits (pipeline squash)
//   busy_cnt   out  registered number of busy registers
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a same-cycle writeback is forwarded to
//                      both read ports (write-first read) and the forwarded
//                      register reads as not busy.
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      NREGS     = 32,
  localparam int unsigned     AW        = $clog2(NREGS),
  parameter bit               ZERO_R0   = 1'b1,
  parameter logic [XLEN-1:0]  RESET_VAL = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            iss_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};

  logic [XLEN-1:0]  regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [AW:0]      cnt_r;
  logic [AW:0]      cnt_nxt_s;

  logic wb_en_s;      // writeback actually updates the data array
  logic iss_r0_s;     // issue targets the hardwired zero register
  logic iss_ready_s;
  logic iss_set_s;    // accepted issue that really sets a busy bit
  logic set_new_s;    // issue sets a bit that was clear
  logic clr_s;        // writeback clears a bit that is not re-set

  logic [XLEN:0] rd1_s;
  logic [XLEN:0] rd2_s;

  // Read one port: {busy, data}. r0 reads 0 when hardwired; with the bypass
  // build a matching writeback is forwarded and the register reads not busy.
  // Forwarding is suppressed while reset is asserted so reads show the reset
  // contents.
  function automatic logic [XLEN:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN:0] res;
    if (ZERO_R0 && (addr == ADDR_ZERO)) begin
      res = {1'b0, {XLEN{1'b0}}};
    end else begin
      res = {busy_r[addr], regs_r[addr]};
`ifdef REGFILE_BYPASS_EN
      if (rst && wb_valid && (wb_rd == addr)) begin
        res = {1'b0, wb_data};
      end else begin
        res = res;
      end
`endif
    end
    return res;
  endfunction

  // Issue/writeback qualification and busy-count deltas.
  always_comb begin
    wb_en_s     = wb_valid & ~(ZERO_R0 & (wb_rd == ADDR_ZERO));
    iss_r0_s    = ZERO_R0 & (iss_rd == ADDR_ZERO);
    // r0 under ZERO_R0 is always ready; its busy bit is never set anyway.
    iss_ready_s = ~busy_r[iss_rd] | (wb_valid & (wb_rd == iss_rd)) | iss_r0_s;
    iss_set_s   = iss_valid & iss_ready_s & ~flush & ~iss_r0_s;
    set_new_s   = iss_set_s & ~busy_r[iss_rd];
    // A same-register issue wins over the release, so nothing is cleared.
    clr_s       = wb_valid & busy_r[wb_rd] & ~(iss_set_s & (iss_rd == wb_rd));
  end

  // Next-state busy array: release on writeback, then reserve on issue.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = {NREGS{1'b0}};
    end else begin
      if (wb_valid) begin
        busy_nxt_s[wb_rd] = 1'b0;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
      if (iss_set_s) begin
        busy_nxt_s[iss_rd] = 1'b1;
      end else begin
        busy_nxt_s = busy_nxt_s;
      end
    end
  end

  // Next busy count, stepped by the same events that change the bit array
  // so that it always equals the population count of busy_r.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (flush) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + {{AW{1'b0}}, set_new_s} - {{AW{1'b0}}, clr_s};
    end
  end

  // Register file data array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (wb_en_s) begin
      regs_r[wb_rd] <= wb_data;
    end else begin
      regs_r[wb_rd] <= regs_r[wb_rd];
    end
  end

  // Scoreboard state: busy bits and their registered count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREGS{1'b0}};
      cnt_r  <= CNT_ZERO;
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Read ports.
  always_comb begin
    rd1_s = read_port(rs1_addr);
    rd2_s = read_port(rs2_addr);
  end

  assign rs1_data  = rd1_s[XLEN-1:0];
  assign rs1_busy  = rd1_s[XLEN];
  assign rs2_data  = rd2_s[XLEN-1:0];
  assign rs2_busy  = rd2_s[XLEN];
  assign iss_ready = iss_ready_s;
  assign busy_cnt  = cnt_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard (XLEN=32, NREGS=32, ZERO_R0=1,
//   RESET_VAL=32'hDEADBEEF). Directed vector table, a behavioural model for
//   random traffic, and hand sequences for async reset and a full scoreboard.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

  localparam int          NR = 32;
  localparam logic [31:0] RV = 32'hDEADBEEF;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic [5:0]  busy_cnt;

  int checks = 0;
  int errors = 0;

  regfile_scoreboard #(
    .XLEN(32), .NREGS(32), .ZERO_R0(1'b1), .RESET_VAL(32'hDEADBEEF)
  ) dut (
    .clk(clk), .rst(rst),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;  logic [4:0] ird;
    logic        wv;  logic [4:0] wrd; logic [31:0] wd;
    logic        fl;  logic [4:0] a1;  logic [4:0] a2;
    logic [31:0] e1;  logic [31:0] e2;
    logic        eb1; logic       eb2; logic erdy; logic [5:0] ecnt;
  } vec_t;

  vec_t tbl[17];

  // Behavioural model: register contents and a set of reserved registers.
  logic [31:0] mreg[NR];
  bit          mbusy[NR];

  function automatic vec_t mk(logic iv, logic [4:0] ird, logic wv, logic [4:0] wrd,
                              logic [31:0] wd, logic fl, logic [4:0] a1, logic [4:0] a2,
                              logic [31:0] e1, logic [31:0] e2, logic eb1, logic eb2,
                              logic erdy, logic [5:0] ecnt);
    vec_t v;
    v.iv = iv; v.ird = ird; v.wv = wv; v.wrd = wrd; v.wd = wd; v.fl = fl;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
    v.erdy = erdy; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [4:0] ird, input logic wv,
                       input logic [4:0] wrd, input logic [31:0] wd, input logic fl,
                       input logic [4:0] a1, input logic [4:0] a2);
    iss_valid = iv; iss_rd = ird; wb_valid = wv; wb_rd = wrd; wb_data = wd;
    flush = fl; rs1_addr = a1; rs2_addr = a2;
  endtask

  function automatic int mcount();
    int n = 0;
    for (int i = 0; i < NR; i++) n += mbusy[i] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (BYP && wb_valid && wb_rd == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (BYP && wb_valid && wb_rd == a) return 1'b0;
    return mbusy[a];
  endfunction

  function automatic logic exp_ready();
    return (iss_rd == 5'd0) || !mbusy[iss_rd] || (wb_valid && wb_rd == iss_rd);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mreg[i] = RV;
      mbusy[i] = 1'b0;
    end
  endtask

  // Apply the current inputs to the model as the next clock edge would.
  task automatic model_step();
    bit rdy;
    rdy = exp_ready();
    if (wb_valid) begin
      if (wb_rd != 5'd0) mreg[wb_rd] = wb_data;
      mbusy[wb_rd] = 1'b0;
    end
    if (flush) begin
      for (int i = 0; i < NR; i++) mbusy[i] = 1'b0;
    end else if (iss_valid && rdy && iss_rd != 5'd0) begin
      mbusy[iss_rd] = 1'b1;
    end
  endtask

  task automatic check_model();
    check("rs1_data", rs1_data, exp_data(rs1_addr));
    check("rs2_data", rs2_data, exp_data(rs2_addr));
    check("rs1_busy", {31'd0, rs1_busy}, {31'd0, exp_busy(rs1_addr)});
    check("rs2_busy", {31'd0, rs2_busy}, {31'd0, exp_busy(rs2_addr)});
    check("iss_ready", {31'd0, iss_ready}, {31'd0, exp_ready()});
    check("busy_cnt", {26'd0, busy_cnt}, mcount());
  endtask

  initial begin
    //            iv  ird   wv  wrd   wd            fl  a1    a2    e1                          e2                          eb1           eb2   rdy   cnt
    tbl[0]  = mk(1'b0, 5'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd7, 5'd0, BYP ? 32'h12345678 : RV,   32'd0,                     1'b0,         1'b0, 1'b1, 6'd0);
    tbl[1]  = mk(1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd7, 5'd0, 32'h12345678,             32'd0,                     1'b0,         1'b0, 1'b1, 6'd0);
    tbl[2]  = mk(1'b1, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd3, 5'd0, RV,                       32'd0,                     1'b0,         1'b0, 1'b1, 6'd0);
    tbl[3]  = mk(1'b1, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd3, 5'd0, RV,                       32'd0,                     1'b1,         1'b0, 1'b0, 6'd1);
    tbl[4]  = mk(1'b0, 5'd3, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd3, 5'd0, BYP ? 32'hA5A5A5A5 : RV,   32'd0,                     !BYP,         1'b0, 1'b1, 6'd1);
    tbl[5]  = mk(1'b0, 5'd3, 1'b0, 5'd0, 32'd0,        1'b0, 5'd3, 5'd0, 32'hA5A5A5A5,             32'd0,                     1'b0,         1'b0, 1'b1, 6'd0);
    tbl[6]  = mk(1'b1, 5'd4, 1'b0, 5'd0, 32'd0,        1'b0, 5'd4, 5'd0, RV,                       32'd0,                     1'b0,         1'b0, 1'b1, 6'd0);
    tbl[7]  = mk(1'b1, 5'd4, 1'b1, 5'd4, 32'h1,        1'b0, 5'd4, 5'd0, BYP ? 32'h1 : RV,          32'd0,                     !BYP,         1'b0, 1'b1, 6'd1);
    tbl[8]  = mk(1'b0, 5'd4, 1'b0, 5'd0, 32'd0,        1'b0, 5'd4, 5'd0, 32'h1,                    32'd0,                     1'b1,         1'b0, 1'b0, 6'd1);
    tbl[9]  = mk(1'b0, 5'd4, 1'b1, 5'd4, 32'd0,        1'b0, 5'd4, 5'd0, BYP ? 32'd0 : 32'h1,       32'd0,                     !BYP,         1'b0, 1'b1, 6'd1);
    tbl[10] = mk(1'b1, 5'd1, 1'b0, 5'd0, 32'd0,        1'b0, 5'd1, 5'd2, RV,                       RV,                        1'b0,         1'b0, 1'b1, 6'd0);
    tbl[11] = mk(1'b1, 5'd2, 1'b0, 5'd0, 32'd0,        1'b0, 5'd1, 5'd2, RV,                       RV,                        1'b1,         1'b0, 1'b1, 6'd1);
    tbl[12] = mk(1'b1, 5'd9, 1'b0, 5'd0, 32'd0,        1'b0, 5'd1, 5'd2, RV,                       RV,                        1'b1,         1'b1, 1'b1, 6'd2);
    tbl[13] = mk(1'b1, 5'd10,1'b1, 5'd2, 32'h55,       1'b1, 5'd9, 5'd10,RV,                       RV,                        1'b1,         1'b0, 1'b1, 6'd3);
    tbl[14] = mk(1'b0, 5'd1, 1'b0, 5'd0, 32'd0,        1'b0, 5'd2, 5'd10,32'h55,                   RV,                        1'b0,         1'b0, 1'b1, 6'd0);
    tbl[15] = mk(1'b0, 5'd0, 1'b1, 5'd6, 32'hCAFE0001, 1'b0, 5'd6, 5'd6, BYP ? 32'hCAFE0001 : RV,   BYP ? 32'hCAFE0001 : RV,   1'b0,         1'b0, 1'b1, 6'd0);
    tbl[16] = mk(1'b0, 5'd0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd6, 5'd6, 32'hCAFE0001,             32'hCAFE0001,              1'b0,         1'b0, 1'b1, 6'd0);

    // Reset state.
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_r5", rs1_data, RV);
    check("reset_r0", rs2_data, 32'd0);
    check("reset_cnt", {26'd0, busy_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vectors; the model follows along for the later phases.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive(tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wrd, tbl[i].wd, tbl[i].fl,
            tbl[i].a1, tbl[i].a2);
      #1;
      check($sformatf("v%0d_rs1_data", i), rs1_data, tbl[i].e1);
      check($sformatf("v%0d_rs2_data", i), rs2_data, tbl[i].e2);
      check($sformatf("v%0d_rs1_busy", i), {31'd0, rs1_busy}, {31'd0, tbl[i].eb1});
      check($sformatf("v%0d_rs2_busy", i), {31'd0, rs2_busy}, {31'd0, tbl[i].eb2});
      check($sformatf("v%0d_iss_ready", i), {31'd0, iss_ready}, {31'd0, tbl[i].erdy});
      check($sformatf("v%0d_busy_cnt", i), {26'd0, busy_cnt}, {26'd0, tbl[i].ecnt});
      model_step();
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 39) == 0,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      #1;
      check_model();
      model_step();
    end

    // Asynchronous reset in the middle of a cycle with busy state present.
    @(negedge clk);
    drive(1'b1, 5'd12, 1'b1, 5'd13, 32'h0BAD0BAD, 1'b0, 5'd13, 5'd0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    drive(1'b0, 5'd12, 1'b0, 5'd0, 32'd0, 1'b0, 5'd13, 5'd0);
    #1;
    check("async_rst_cnt", {26'd0, busy_cnt}, 32'd0);
    check("async_rst_data", rs1_data, RV);
    check("async_rst_busy", {31'd0, rs1_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reserve every register, r0 included: count must top out at NREGS-1.
    for (int r = 0; r < NR; r++) begin
      @(negedge clk);
      drive(1'b1, 5'(r), 1'b0, 5'd0, 32'd0, 1'b0, 5'(r), 5'd31);
      #1;
      check_model();
      model_step();
    end
    @(negedge clk);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd17);
    #1;
    check("full_cnt", {26'd0, busy_cnt}, 32'd31);
    check("full_r0_ready", {31'd0, iss_ready}, 32'd1);
    check("full_r17_busy", {31'd0, rs2_busy}, 32'd1);
    check("full_r0_busy", {31'd0, rs1_busy}, 32'd0);
    model_step();

    // Flush from a full scoreboard.
    @(negedge clk);
    drive(1'b0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 5'd6);
    #1;
    model_step();
    @(negedge clk);
    drive(1'b0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd5, 5'd6);
    #1;
    check("flush_cnt", {26'd0, busy_cnt}, 32'd0);
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
